// File: rtl/vx_alu_commit_queue.sv
// Purpose  : elastic in-order commit queue between the ALU pipe and the writeback/commit arbiter.
// Latency  : 1 cycle minimum (no bypass); sustains 1 packet/cycle once non-empty.
// Backpress: in_ready comes from occupancy only, so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, reset (async active-low)
//   in_valid/in_ready + in_{uuid,wid,tmask,PC,rd,wb,data}     : commit packet from ALU/MUL
//   out_valid/out_ready + out_{uuid,wid,tmask,PC,rd,wb,data}  : head entry to the arbiter
//   out_eop (always 1), count (occupancy), perf_stalls (saturating stall cycles)
module vx_alu_commit_queue #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int UUID_BITS   = 44,
    parameter int DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_BITS-1:0]        in_uuid,
    input  logic [NW_BITS-1:0]          in_wid,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [31:0]                 in_PC,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic                        in_wb,
    input  logic [NUM_THREADS*32-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_BITS-1:0]        out_uuid,
    output logic [NW_BITS-1:0]          out_wid,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [31:0]                 out_PC,
    output logic [NR_BITS-1:0]          out_rd,
    output logic                        out_wb,
    output logic [NUM_THREADS*32-1:0]   out_data,
    output logic                        out_eop,
    output logic [$clog2(DEPTH):0]      count,
    output logic [31:0]                 perf_stalls
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [UUID_BITS-1:0]      uuid;
        logic [NW_BITS-1:0]        wid;
        logic [NUM_THREADS-1:0]    tmask;
        logic [31:0]               pc;
        logic [NR_BITS-1:0]        rd;
        logic                      wb;
        logic [NUM_THREADS*32-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          in_ent;
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [31:0]     stalls_q, stalls_d;
    logic            push;
    logic            pop;

    assign in_ent = '{uuid: in_uuid, wid: in_wid, tmask: in_tmask, pc: in_PC,
                      rd: in_rd, wb: in_wb, data: in_data};

    // Full/empty come from the occupancy counter; the pointers alias when full.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stalls_d = stalls_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (in_valid && !in_ready && (stalls_q != '1)) stalls_d = stalls_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stalls_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stalls_q <= stalls_d;
        end
    end

    // Payload storage carries no reset; its contents only matter while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_ent;
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_uuid    = head.uuid;
    assign out_wid     = head.wid;
    assign out_tmask   = head.tmask;
    assign out_PC      = head.pc;
    assign out_rd      = head.rd;
    assign out_wb      = head.wb;
    assign out_data    = head.data;
    assign out_eop     = 1'b1;
    assign count       = count_q;
    assign perf_stalls = stalls_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!reset) count_q <= CW'(DEPTH));
    a_no_ovf_push: assert property (@(posedge clk) disable iff (!reset) push |-> (count_q != CW'(DEPTH)));
    a_no_udf_pop:  assert property (@(posedge clk) disable iff (!reset) pop |-> (count_q != '0));
endmodule

// File: tb/tb_vx_alu_commit_queue.sv
module tb_vx_alu_commit_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [43:0]  uuid;
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic         wb;
        logic [127:0] data;
    } pkt_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [43:0]  in_uuid = '0;
    logic [1:0]   in_wid = '0;
    logic [3:0]   in_tmask = '0;
    logic [31:0]  in_PC = '0;
    logic [4:0]   in_rd = '0;
    logic         in_wb = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [43:0]  out_uuid;
    logic [1:0]   out_wid;
    logic [3:0]   out_tmask;
    logic [31:0]  out_PC;
    logic [4:0]   out_rd;
    logic         out_wb;
    logic [127:0] out_data;
    logic         out_eop;
    logic [2:0]   count;
    logic [31:0]  perf_stalls;

    vx_alu_commit_queue #(.NUM_THREADS(4), .NW_BITS(2), .NR_BITS(5), .UUID_BITS(44), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC),
        .in_rd(in_rd), .in_wb(in_wb), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC),
        .out_rd(out_rd), .out_wb(out_wb), .out_data(out_data),
        .out_eop(out_eop), .count(count), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a queue of accepted packets plus a stall counter.
    pkt_t        exp_q[$];
    longint      m_stalls = 0;
    bit          last_acc = 1'b0;
    int          wb0_retired = 0;
    int          retired = 0;
    logic [43:0] next_uuid = 44'd100;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the model each cycle, then advances the
    // model by what the coming rising edge will do with the current inputs.
    always @(negedge clk) begin
        int   sz;
        pkt_t got;
        if (reset) begin
            sz = exp_q.size();
            chk("out_valid", 256'(out_valid), 256'(sz != 0));
            chk("in_ready", 256'(in_ready), 256'(sz != DEPTH));
            chk("count", 256'(count), 256'(sz));
            chk("perf_stalls", 256'(perf_stalls), 256'(m_stalls));
            chk("out_eop", 256'(out_eop), 256'(1));
            if (out_ready && sz != 0) begin
                got = '{uuid: out_uuid, wid: out_wid, tmask: out_tmask, pc: out_PC,
                        rd: out_rd, wb: out_wb, data: out_data};
                chk("head_pkt", 256'(got), 256'(exp_q[0]));
                if (!exp_q[0].wb) wb0_retired++;
                retired++;
                void'(exp_q.pop_front());
            end
            if (in_valid && sz == DEPTH && m_stalls != 64'hFFFF_FFFF) m_stalls++;
            last_acc = in_valid && (sz != DEPTH);
            if (last_acc)
                exp_q.push_back('{uuid: in_uuid, wid: in_wid, tmask: in_tmask, pc: in_PC,
                                  rd: in_rd, wb: in_wb, data: in_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [43:0] u);
        in_uuid  = u;
        in_wid   = 2'($urandom);
        in_tmask = 4'($urandom);
        in_PC    = $urandom;
        in_rd    = 5'($urandom);
        in_wb    = ($urandom_range(0, 99) >= 30);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic wait_accept(input int budget);
        int n = 0;
        tick();
        while (!last_acc && n < budget) begin
            tick();
            n++;
        end
        chk("accept_in_time", 256'(last_acc), 256'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_stalls", 256'(perf_stalls), 256'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // 1: single packet, one-cycle latency
        out_ready = 1'b1;
        set_pkt(44'd5);
        in_rd = 5'd3;
        in_data[31:0] = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 256'(out_valid), 256'(1));
        chk("t1_uuid", 256'(out_uuid), 256'(5));
        chk("t1_rd", 256'(out_rd), 256'(3));
        chk("t1_lane0", 256'(out_data[31:0]), 256'(32'hDEAD));
        tick();
        @(negedge clk);
        chk("t1_count_back", 256'(count), 256'(0));

        // 2: fill, stall 3 cycles, then drain in order
        tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_pkt(44'(i));
            tick();
        end
        set_pkt(44'd5);
        repeat (3) tick();
        @(negedge clk);
        chk("t2_full_count", 256'(count), 256'(4));
        chk("t2_full_ready", 256'(in_ready), 256'(0));
        chk("t2_stalls3", 256'(perf_stalls), 256'(3));
        out_ready = 1'b1;
        wait_accept(8);
        drain(16);

        // 3: full with pop and push offered together
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_pkt(next_uuid++);
            tick();
        end
        out_ready = 1'b1;
        set_pkt(next_uuid++);
        tick();
        @(negedge clk);
        chk("t3_pop_only", 256'(count), 256'(3));
        tick();
        @(negedge clk);
        chk("t3_push_pop", 256'(count), 256'(3));
        drain(16);

        // 4: 100 back-to-back packets
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_pkt(next_uuid++);
            tick();
        end
        drain(16);

        // 5: random traffic, holding a refused packet stable
        in_valid = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 99) < 70) set_pkt(next_uuid++);
                else in_valid = 1'b0;
            end
            out_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        drain(16);
        chk("t5_wb0_seen", 256'(wb0_retired > 0), 256'(1));

        // 6: asynchronous reset with 3 entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pkt(next_uuid++);
            tick();
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", 256'(out_valid), 256'(0));
        chk("t6_count", 256'(count), 256'(0));
        chk("t6_stalls", 256'(perf_stalls), 256'(0));
        chk("t6_ready", 256'(in_ready), 256'(1));
        exp_q.delete();
        m_stalls = 0;
        last_acc = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        set_pkt(next_uuid++);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_sole_entry", 256'(count), 256'(1));
        drain(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
